// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs and stall/flush controls exchanged
// between the core datapath (master) and the hazard sequencer (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       i_rs1_addr_D;
  logic [4:0]       i_rs2_addr_D;
  logic             i_rs1_used_D;
  logic             i_rs2_used_D;
  logic [4:0]       i_rd_addr_E;
  logic             i_mem_rden_E;
  logic             i_br_taken_E;
  logic             i_mc_op_E;
  logic             i_mc_done;
  logic             i_dmem_req_M;
  logic             i_dmem_ack;
  logic             o_stall_F;
  logic             o_stall_D;
  logic             o_stall_E;
  logic             o_stall_M;
  logic             o_flush_D;
  logic             o_flush_E;
  logic             o_flush_M;
  logic             o_flush_W;
  logic             o_mc_start;
  logic             o_busy;
  logic [CNT_W-1:0] o_stall_cnt;
  logic             o_mc_timeout;

  modport master (
    output i_rs1_addr_D, i_rs2_addr_D, i_rs1_used_D, i_rs2_used_D,
    output i_rd_addr_E, i_mem_rden_E, i_br_taken_E, i_mc_op_E,
    output i_mc_done, i_dmem_req_M, i_dmem_ack,
    input  o_stall_F, o_stall_D, o_stall_E, o_stall_M,
    input  o_flush_D, o_flush_E, o_flush_M, o_flush_W,
    input  o_mc_start, o_busy, o_stall_cnt, o_mc_timeout
  );

  modport slave (
    input  i_rs1_addr_D, i_rs2_addr_D, i_rs1_used_D, i_rs2_used_D,
    input  i_rd_addr_E, i_mem_rden_E, i_br_taken_E, i_mc_op_E,
    input  i_mc_done, i_dmem_req_M, i_dmem_ack,
    output o_stall_F, o_stall_D, o_stall_E, o_stall_M,
    output o_flush_D, o_flush_E, o_flush_M, o_flush_W,
    output o_mc_start, o_busy, o_stall_cnt, o_mc_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: per-stage stall/flush
// controls, MUL/DIV start handshake, stall-cycle counter and MC timeout flag.
module hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  hazard_ctrl_if.slave hz
);

  localparam int TO_W = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MC  = 2'd1,
    S_MEM = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;
  logic w_mc_start;
  logic w_mem_wait;
  logic w_load_use;

  assign w_mem_wait = hz.i_dmem_req_M & ~hz.i_dmem_ack;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_load_use = hz.i_mem_rden_E & (hz.i_rd_addr_E != 5'd0) &
                      ((hz.i_rs1_used_D & (hz.i_rs1_addr_D == hz.i_rd_addr_E)) |
                       (hz.i_rs2_used_D & (hz.i_rs2_addr_D == hz.i_rd_addr_E)));

  // Next-state and stall/flush decode; everything is held low during reset
  always_comb begin
    w_next     = r_state;
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_m  = 1'b0;
    w_flush_w  = 1'b0;
    w_mc_start = 1'b0;
    if (i_reset) begin
      case (r_state)
        S_RUN: begin
          if (w_mem_wait) begin
            {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
            w_flush_w = 1'b1;
            w_next    = S_MEM;
          end else if (hz.i_mc_op_E) begin
            {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
            w_flush_m  = 1'b1;
            w_mc_start = 1'b1;
            w_next     = S_MC;
          end else if (hz.i_br_taken_E) begin
            // redirect kills the D instruction, so a pending load-use is moot
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_next    = S_RUN;
          end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
            w_next    = S_RUN;
          end else begin
            w_next = S_RUN;
          end
        end
        S_MEM: begin
          if (!hz.i_dmem_ack) begin
            {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
            w_flush_w = 1'b1;
            w_next    = S_MEM;
          end else begin
            w_next = S_RUN;
          end
        end
        S_MC: begin
          if (!hz.i_mc_done) begin
            {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
            w_flush_m = 1'b1;
            w_next    = S_MC;
          end else begin
            w_next = S_RUN;
          end
        end
        default: begin
          w_next = S_RUN;
        end
      endcase
    end else begin
      w_next = S_RUN;
    end
  end

  // State register, saturating stall counter and sticky MC timeout tracking
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_RUN;
      r_stall_cnt <= '0;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((r_state == S_RUN) && (w_next == S_MC)) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_MC) && !hz.i_mc_done &&
                   (r_to_cnt != TO_W'(MC_TIMEOUT))) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
        if (r_to_cnt == TO_W'(MC_TIMEOUT - 1)) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign hz.o_stall_F    = w_stall_f;
  assign hz.o_stall_D    = w_stall_d;
  assign hz.o_stall_E    = w_stall_e;
  assign hz.o_stall_M    = w_stall_m;
  assign hz.o_flush_D    = w_flush_d;
  assign hz.o_flush_E    = w_flush_e;
  assign hz.o_flush_M    = w_flush_m;
  assign hz.o_flush_W    = w_flush_w;
  assign hz.o_mc_start   = w_mc_start;
  assign hz.o_busy       = (r_state != S_RUN);
  assign hz.o_stall_cnt  = r_stall_cnt;
  assign hz.o_mc_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-bit stall counter and MC_TIMEOUT=4.
module tb_hazard_ctrl;

  localparam int CNT_W      = 4;
  localparam int MC_TIMEOUT = 4;

  // {stall F,D,E,M, flush D,E,M,W, mc_start, busy}
  localparam logic [9:0] CTL_IDLE = 10'b0000000000;
  localparam logic [9:0] CTL_LU   = 10'b1100010000;
  localparam logic [9:0] CTL_BR   = 10'b0000110000;
  localparam logic [9:0] CTL_MCS  = 10'b1110001010;
  localparam logic [9:0] CTL_MCW  = 10'b1110001001;
  localparam logic [9:0] CTL_MEMR = 10'b1111000100;
  localparam logic [9:0] CTL_MEMW = 10'b1111000101;
  localparam logic [9:0] CTL_REL  = 10'b0000000001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [9:0] ctl;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .hz      (hz)
  );

  assign ctl = {hz.o_stall_F, hz.o_stall_D, hz.o_stall_E, hz.o_stall_M,
                hz.o_flush_D, hz.o_flush_E, hz.o_flush_M, hz.o_flush_W,
                hz.o_mc_start, hz.o_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hz.i_rs1_addr_D = 5'd0;
    hz.i_rs2_addr_D = 5'd0;
    hz.i_rs1_used_D = 1'b0;
    hz.i_rs2_used_D = 1'b0;
    hz.i_rd_addr_E  = 5'd0;
    hz.i_mem_rden_E = 1'b0;
    hz.i_br_taken_E = 1'b0;
    hz.i_mc_op_E    = 1'b0;
    hz.i_mc_done    = 1'b0;
    hz.i_dmem_req_M = 1'b0;
    hz.i_dmem_ack   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clr();
    hz.i_dmem_req_M = 1'b1;
    #2;
    chk("rst_ctl_forced", 32'(ctl), 32'(CTL_IDLE));
    chk("rst_cnt", 32'(hz.o_stall_cnt), 32'd0);
    chk("rst_timeout", 32'(hz.o_mc_timeout), 32'd0);
    tick();
    tick();
    clr();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(ctl), 32'(CTL_IDLE));

    // load x5 in E, D reads x5 through rs2
    tick();
    hz.i_rd_addr_E = 5'd5; hz.i_mem_rden_E = 1'b1;
    hz.i_rs1_addr_D = 5'd3; hz.i_rs1_used_D = 1'b1;
    hz.i_rs2_addr_D = 5'd5; hz.i_rs2_used_D = 1'b1;
    #1;
    chk("lu_rs2", 32'(ctl), 32'(CTL_LU));
    tick();
    clr();
    #1;
    chk("lu_released", 32'(ctl), 32'(CTL_IDLE));
    chk("lu_cnt", 32'(hz.o_stall_cnt), 32'd1);

    // x0 never stalls; unused operand never stalls; branch beats load-use
    hz.i_rd_addr_E = 5'd0; hz.i_mem_rden_E = 1'b1;
    hz.i_rs1_addr_D = 5'd0; hz.i_rs1_used_D = 1'b1;
    #1;
    chk("lu_x0", 32'(ctl), 32'(CTL_IDLE));
    hz.i_rd_addr_E = 5'd7; hz.i_rs1_addr_D = 5'd1;
    hz.i_rs2_addr_D = 5'd7; hz.i_rs2_used_D = 1'b0;
    #1;
    chk("lu_unused_rs2", 32'(ctl), 32'(CTL_IDLE));
    hz.i_rd_addr_E = 5'd5; hz.i_rs1_addr_D = 5'd5; hz.i_br_taken_E = 1'b1;
    #1;
    chk("br_over_lu", 32'(ctl), 32'(CTL_BR));

    // multi-cycle op, done arrives on the 5th cycle after the start cycle
    tick();
    clr();
    hz.i_mc_op_E = 1'b1;
    #1;
    chk("mc_start", 32'(ctl), 32'(CTL_MCS));
    tick();
    for (int k = 1; k <= 4; k++) begin
      hz.i_br_taken_E = (k == 2);
      #1;
      chk("mc_wait", 32'(ctl), 32'(CTL_MCW));
      chk("mc_to_clear", 32'(hz.o_mc_timeout), 32'd0);
      hz.i_br_taken_E = 1'b0;
      tick();
    end
    hz.i_mc_done = 1'b1;
    #1;
    chk("mc_done", 32'(ctl), 32'(CTL_REL));
    chk("mc_cnt", 32'(hz.o_stall_cnt), 32'd6);
    chk("mc_to_after4", 32'(hz.o_mc_timeout), 32'd1);
    tick();
    #1;
    chk("mc_b2b_start", 32'(ctl), 32'(CTL_MCS));
    tick();
    #1;
    chk("mc_b2b_done", 32'(ctl), 32'(CTL_REL));
    chk("mc_b2b_cnt", 32'(hz.o_stall_cnt), 32'd7);
    tick();
    clr();
    #1;
    chk("mc_back_run", 32'(ctl), 32'(CTL_IDLE));

    // dmem request acked after 3 wait cycles
    hz.i_dmem_req_M = 1'b1;
    #1;
    chk("mem_first", 32'(ctl), 32'(CTL_MEMR));
    tick();
    hz.i_br_taken_E = 1'b1;
    #1;
    chk("mem_wait2_br_ignored", 32'(ctl), 32'(CTL_MEMW));
    hz.i_br_taken_E = 1'b0;
    tick();
    #1;
    chk("mem_wait3", 32'(ctl), 32'(CTL_MEMW));
    tick();
    hz.i_dmem_ack = 1'b1;
    #1;
    chk("mem_ack", 32'(ctl), 32'(CTL_REL));
    chk("mem_cnt", 32'(hz.o_stall_cnt), 32'd10);
    tick();
    #1;
    chk("mem_same_cycle_ack", 32'(ctl), 32'(CTL_IDLE));
    hz.i_dmem_ack = 1'b0; hz.i_mc_op_E = 1'b1; hz.i_br_taken_E = 1'b1;
    #1;
    chk("mem_priority", 32'(ctl), 32'(CTL_MEMR));
    tick();
    hz.i_mc_op_E = 1'b0; hz.i_br_taken_E = 1'b0; hz.i_dmem_ack = 1'b1;
    #1;
    chk("mem_prio_ack", 32'(ctl), 32'(CTL_REL));
    tick();
    clr();
    #1;
    chk("mem_cnt2", 32'(hz.o_stall_cnt), 32'd11);

    // held load-use drives the 4-bit counter into saturation
    hz.i_rd_addr_E = 5'd9; hz.i_mem_rden_E = 1'b1;
    hz.i_rs1_addr_D = 5'd9; hz.i_rs1_used_D = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_14", 32'(hz.o_stall_cnt), 32'd14);
    tick();
    chk("sat_15", 32'(hz.o_stall_cnt), 32'd15);
    tick();
    tick();
    chk("sat_hold", 32'(hz.o_stall_cnt), 32'd15);

    // asynchronous reset in the middle of an MC op
    clr();
    tick();
    hz.i_mc_op_E = 1'b1;
    tick();
    #1;
    chk("pre_rst_mc", 32'(ctl), 32'(CTL_MCW));
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl), 32'(CTL_IDLE));
    chk("rst_async_cnt", 32'(hz.o_stall_cnt), 32'd0);
    chk("rst_async_to", 32'(hz.o_mc_timeout), 32'd0);
    tick();
    chk("rst_held_ctl", 32'(ctl), 32'(CTL_IDLE));
    rst_n = 1'b1;
    #1;
    chk("rst_rel_start", 32'(ctl), 32'(CTL_MCS));

    // done withheld for 10 S_MC cycles
    tick();
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("to_flag", 32'(hz.o_mc_timeout), (k >= 5) ? 32'd1 : 32'd0);
      chk("to_wait_ctl", 32'(ctl), 32'(CTL_MCW));
      tick();
    end
    hz.i_mc_done = 1'b1;
    #1;
    chk("to_done", 32'(ctl), 32'(CTL_REL));
    chk("to_cnt", 32'(hz.o_stall_cnt), 32'd11);
    tick();
    clr();
    #1;
    chk("to_end_idle", 32'(ctl), 32'(CTL_IDLE));
    chk("to_sticky", 32'(hz.o_mc_timeout), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline hazard sequencer for the 5-stage RV32 core (F/D/E/M/W). It generates per-stage stall and flush controls for four hazard types:
- load-use hazards
- taken branches/jumps resolved in E
- multi-cycle execute ops (MUL/DIV unit, start/done handshake)
- data-memory wait states (req/ack handshake)

Its controls work alongside the operand forwarding unit. It also keeps a saturating stall-cycle counter and a sticky multi-cycle timeout flag.

Parameters:
CNT_W, 32, width of the stall-cycle performance counter
MC_TIMEOUT, 64, cycles in S_MC without i_mc_done before o_mc_timeout sets (≥2)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_rs1_addr_D  in  5  rs1 of instruction in D
i_rs2_addr_D  in  5  rs2 of instruction in D
i_rs1_used_D  in  1  D instruction reads rs1
i_rs2_used_D  in  1  D instruction reads rs2
i_rd_addr_E  in  5  rd of instruction in E
i_mem_rden_E  in  1  E instruction is a load
i_br_taken_E  in  1  E resolved taken branch/jump (redirect)
i_mc_op_E  in  1  E instruction is a multi-cycle op
i_mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
i_dmem_req_M  in  1  M instruction accesses data memory
i_dmem_ack  in  1  data memory completes access this cycle
o_stall_F  out  1  hold PC
o_stall_D  out  1  hold F/D register
o_stall_E  out  1  hold D/E register
o_stall_M  out  1  hold E/M register
o_flush_D  out  1  clear F/D register (bubble into D)
o_flush_E  out  1  clear D/E register (bubble into E)
o_flush_M  out  1  clear E/M register (bubble into M)
o_flush_W  out  1  clear M/W register (bubble into W)
o_mc_start  out  1  start pulse to multi-cycle unit
o_busy  out  1  state != S_RUN
o_stall_cnt  out  CNT_W  cycles with o_stall_F=1, saturating
o_mc_timeout  out  1  sticky: multi-cycle op exceeded MC_TIMEOUT

Behaviour:
States: S_RUN, S_MC, S_MEM. Only state and counters are registered; all stall/flush/start outputs are combinational from state and inputs.

Reset (i_reset=0, asynchronous):
- state=S_RUN; o_stall_cnt=0; o_mc_timeout=0; internal timeout counter=0.
- All stall/flush outputs and o_mc_start forced 0 while reset is asserted; o_busy=0.
- Reset mid-op abandons the op; the MUL/DIV unit shares the same reset.

S_RUN — evaluate in priority order; the first match wins:
1. Mem wait (i_dmem_req_M & ~i_dmem_ack): stall F, D, E, M; flush W; next S_MEM. Same-cycle ack costs no stall.
2. Multi-cycle (i_mc_op_E): o_mc_start=1 for exactly this cycle; stall F, D, E; flush M; next S_MC. i_mc_done is ignored in S_RUN.
3. Branch (i_br_taken_E): flush D and E; no stall. This overrides load-use, because the dependent instruction is killed.
4. Load-use (i_mem_rden_E & i_rd_addr_E≠0 & ((i_rs1_used_D & rs1==rd_E) | (i_rs2_used_D & rs2==rd_E))): stall F, D; flush E; one cycle only, since the load advances. Register x0 never triggers a load-use stall.
5. Otherwise: all outputs 0.

S_MEM:
- While ~i_dmem_ack: stall F, D, E, M; flush W.
- On the ack cycle: all controls 0 (pipeline advances); next S_RUN.

S_MC:
- While ~i_mc_done: stall F, D, E; flush M; o_mc_start=0.
- On the i_mc_done cycle: controls 0, so E advances with the result; next S_RUN.
- A back-to-back mc op in E re-enters S_MC after one S_RUN cycle with a new start pulse.
- Timeout counter clears on entry to S_MC and increments each S_MC cycle. When it reaches MC_TIMEOUT, o_mc_timeout sets. The block keeps waiting; the flag clears only on reset.

Counter:
- o_stall_cnt increments on every clock with o_stall_F=1 and holds at 2^CNT_W−1.

Boundary rules:
- i_br_taken_E is ignored in S_MC and S_MEM, because E is held; it is acted on when E releases.
- A mem wait arising while the state is S_MC is impossible, because M holds a bubble. No requirement applies to it.

Test Plan:
- Load x5 in E, D reads rs2=x5 (used) → one cycle: stall_F=stall_D=1, flush_E=1; next cycle all 0; stall_cnt=1.
- Load rd=x0 in E, D reads x0 → no stall; taken branch plus load-use in the same cycle → flush_D=flush_E=1, stall_F=0.
- mc op in E, i_mc_done 5 cycles after start → o_mc_start is a one-cycle pulse; stall_F/D/E and flush_M high for 5 cycles, all 0 on the done cycle; stall_cnt=5; back-to-back op → second start pulse one cycle later.
- dmem req with ack after 3 wait cycles → stall F–M plus flush_W for 3 cycles; ack cycle clean; with MC_TIMEOUT=4 and done withheld 10 cycles → o_mc_timeout=1 from cycle 4, sticky after done.
- Reset asserted mid S_MC → outputs 0 immediately (asynchronous); after release state=S_RUN, stall_cnt=0, timeout=0; saturation with CNT_W=4 → counter holds at 15.
